// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants, drain FSM states and FIFO entry layout for the MM result drain
package mm_pkg;

  localparam int MM_IDX_W = 20;
  localparam int MM_ACC_W = 40;
  localparam int MM_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [MM_IDX_W-1:0] row;
    logic [MM_IDX_W-1:0] col;
    logic [MM_OUT_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/mm_sync_fifo.sv
// rtl/mm_sync_fifo.sv - single-clock FIFO with occupancy counter and combinational head read
module mm_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the same-cycle push lands in, so full only blocks a push without a pop
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy disambiguates full and empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_result_drain.sv
// rtl/mm_result_drain.sv - buffers MM C-element writes and drains them as a stream; MM_DRAIN_SATURATE_EN selects clamping over truncation
module mm_result_drain
  import mm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = MM_IDX_W,
  parameter int ACC_W = MM_ACC_W,
  parameter int OUT_W = MM_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [ACC_W-1:0] wr_data,
  input  logic             mm_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] elem_count,
  output logic             overflow,
  output logic             done
);

  localparam int WIDTH = 2 * IDX_W + OUT_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] conv_data;
  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] unused_occupancy;
  drain_state_t     state;

  // MM cannot be stalled: a write is taken whenever a slot is free or being freed, otherwise lost
  assign pop  = ~empty & out_ready;
  assign push = wr_valid & (~full | pop);

`ifdef MM_DRAIN_SATURATE_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};
  logic fits;

  // Value is representable when all bits above the output sign bit replicate it
  assign fits      = (wr_data[ACC_W-1:OUT_W-1] == {(ACC_W - OUT_W + 1){wr_data[OUT_W-1]}});
  assign conv_data = fits ? wr_data[OUT_W-1:0] : (wr_data[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
  logic unused_high;

  assign unused_high = ^wr_data[ACC_W-1:OUT_W];
  assign conv_data   = wr_data[OUT_W-1:0];
`endif

  mm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_row, wr_col, conv_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (unused_occupancy)
  );

  // Outputs read zero while nothing is buffered so stale storage never leaks out
  assign out_valid                   = ~empty;
  assign {out_row, out_col, out_data} = empty ? '0 : head;

  // Drain FSM with element counter, sticky loss flag and registered done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      elem_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      elem_count <= elem_count + IDX_W'(push);
      if (wr_valid & ~push) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (mm_finish) begin
            state <= FLUSH;
          end else if (push) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (mm_finish) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (empty & ~push) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // Leaving DONE clears the count; a push arriving now is the first of the next result
          elem_count <= IDX_W'(push);
          state      <= push ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_drain.sv
// tb/tb_mm_result_drain.sv - scoreboard bench for mm_result_drain
module tb_mm_result_drain;

  localparam int DEPTH = 16;
  localparam int IDX_W = 20;
  localparam int ACC_W = 40;
  localparam int OUT_W = 32;
  localparam int EW    = 2 * IDX_W + OUT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic [IDX_W-1:0] wr_row = '0;
  logic [IDX_W-1:0] wr_col = '0;
  logic [ACC_W-1:0] wr_data = '0;
  logic             mm_finish = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] elem_count;
  logic             overflow;
  logic             done;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               done_cnt = 0;
  logic [IDX_W-1:0] done_elem = '0;
  bit               valid_seen = 1'b0;
  logic [EW-1:0]    exp_q[$];
  logic [OUT_W-1:0] e_big;
  logic [OUT_W-1:0] e_neg;
  int               start;

  always #5 clk = ~clk;

  mm_result_drain #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .mm_finish  (mm_finish),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_data   (out_data),
    .elem_count (elem_count),
    .overflow   (overflow),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, records done pulses
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset && out_valid) valid_seen = 1'b1;
    if (!reset && done) begin
      done_cnt++;
      done_elem = elem_count;
    end
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got %0h required none", {out_row, out_col, out_data});
      end else begin
        e = exp_q.pop_front();
        if ({out_row, out_col, out_data} !== e) begin
          n_bad++;
          $display("FAIL beat: got %0h required %0h", {out_row, out_col, out_data}, e);
        end
      end
    end
  end

  task automatic write(input int row, input int col, input logic [ACC_W-1:0] d,
                       input logic [OUT_W-1:0] e, input bit keep);
    wr_valid = 1'b1;
    wr_row   = row[IDX_W-1:0];
    wr_col   = col[IDX_W-1:0];
    wr_data  = d;
    if (keep) exp_q.push_back({row[IDX_W-1:0], col[IDX_W-1:0], e});
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic finish_pulse();
    mm_finish = 1'b1;
    @(posedge clk);
    #1;
    mm_finish = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int s;
    s = done_cnt;
    for (int i = 0; i < 300 && done_cnt == s; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt - s), 64'd1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wr_valid  = 1'b0;
    mm_finish = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_elem_count", 64'(elem_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1) 2x2 result streamed straight through
    out_ready = 1'b1;
    write(0, 0, 40'd5, 32'd5, 1'b1);
    write(0, 1, 40'hFF_FFFF_FFFD, 32'hFFFF_FFFD, 1'b1);
    write(1, 0, 40'd7, 32'd7, 1'b1);
    write(1, 1, 40'd0, 32'd0, 1'b1);
    finish_pulse();
    wait_done("t1");
    check("t1_elem_at_done", 64'(done_elem), 64'd4);
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t1_elem_cleared", 64'(elem_count), 64'd0);

    // 2) Overfill with consumer stalled
    do_reset();
    for (int i = 0; i < DEPTH; i++) write(2, i, ACC_W'(i * 3 + 1), OUT_W'(i * 3 + 1), 1'b1);
    check("t2_ovf_at_full", 64'(overflow), 64'd0);
    write(2, DEPTH, 40'd99, 32'd99, 1'b0);
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_elem_count", 64'(elem_count), 64'd16);
    check("t2_head_col", 64'(out_col), 64'd0);
    out_ready = 1'b1;
    finish_pulse();
    wait_done("t2");
    check("t2_elem_at_done", 64'(done_elem), 64'd16);
    check("t2_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);

    // 3) Full FIFO, push and pop in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) write(3, i, ACC_W'(100 + i), OUT_W'(100 + i), 1'b1);
    out_ready = 1'b1;
    write(3, DEPTH, 40'd200, 32'd200, 1'b1);
    out_ready = 1'b0;
    check("t3_overflow", 64'(overflow), 64'd0);
    check("t3_occupancy", 64'(dut.u_fifo.count), 64'd16);
    check("t3_elem_count", 64'(elem_count), 64'd17);
    check("t3_head_col", 64'(out_col), 64'd1);
    out_ready = 1'b1;
    finish_pulse();
    wait_done("t3");
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4) Narrowing of out-of-range values
`ifdef MM_DRAIN_SATURATE_EN
    e_big = 32'h7FFF_FFFF;
    e_neg = 32'h8000_0000;
`else
    e_big = 32'h8000_0000;
    e_neg = 32'h0000_0000;
`endif
    do_reset();
    out_ready = 1'b1;
    write(4, 0, 40'h00_8000_0000, e_big, 1'b1);
    write(4, 1, 40'hF8_0000_0000, e_neg, 1'b1);
    write(4, 2, 40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    finish_pulse();
    wait_done("t4");
    check("t4_elem_at_done", 64'(done_elem), 64'd3);
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // 5) Finish with nothing written
    do_reset();
    valid_seen = 1'b0;
    start = done_cnt;
    finish_pulse();
    check("t5_done_flush", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    check("t5_done_pulse", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    check("t5_done_after", 64'(done), 64'd0);
    check("t5_pulse_count", 64'(done_cnt - start), 64'd1);
    check("t5_valid_never", 64'(valid_seen), 64'd0);

    // 6) Reset with entries queued
    do_reset();
    write(6, 0, 40'd1, 32'd1, 1'b0);
    write(6, 1, 40'd2, 32'd2, 1'b0);
    write(6, 2, 40'd3, 32'd3, 1'b0);
    check("t6_valid_before", 64'(out_valid), 64'd1);
    check("t6_elem_before", 64'(elem_count), 64'd3);
    start = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_rst", 64'(out_valid), 64'd0);
    check("t6_ovf_rst", 64'(overflow), 64'd0);
    check("t6_elem_rst", 64'(elem_count), 64'd0);
    check("t6_data_rst", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_done", 64'(done_cnt - start), 64'd0);
    check("t6_valid_after", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
